// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and state type for the four-lane round-robin mux arbiter.
package mux_arb_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle for the arbiter: request lines, packed lanes and the granted output.
interface mux4_rr_arbiter_if #(parameter int WIDTH = 2);
  import mux_arb_pkg::*;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data;
  logic [N_REQ-1:0]       grant;
  logic [SEL_W-1:0]       sel;
  logic [WIDTH-1:0]       m;
  logic                   m_valid;

  modport master (output req, data, input grant, sel, m, m_valid);
  modport slave  (input req, data, output grant, sel, m, m_valid);
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req starting at start, wrapping mod 4.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [SEL_W-1:0] cand_idx;

  always_comb begin
    found    = 1'b0;
    idx      = start;
    onehot   = '0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_idx = start + SEL_W'(k);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
    if (found)
      onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of the 4:1 lane mux: one grant at a time, preemptible after MAX_HOLD cycles.
// state | meaning
// IDLE  | no lane granted, m forced to 0, sel holds its previous value
// GRANT | lane sel_q owns the mux, hold_cnt counts up to MAX_HOLD-1
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int MAX_HOLD = 4
)(
  input  logic               CLOCK_50,
  input  logic               reset,
  mux4_rr_arbiter_if.slave   bus
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  arb_state_t       state_q;
  logic [N_REQ-1:0] grant_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] last_q;
  logic [3:0]       hold_cnt;

  logic [SEL_W-1:0] start;
  logic [N_REQ-1:0] cand;
  logic             found;
  logic [SEL_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic             cur_req;
  logic             switch_lane;

  // Masking the current lane makes one search serve both release and preempt.
  assign start       = (state_q == IDLE) ? last_q + 2'd1 : sel_q + 2'd1;
  assign cand        = bus.req & ~grant_q;
  assign cur_req     = |(bus.req & grant_q);
  assign switch_lane = !cur_req || ((hold_cnt == HOLD_LAST) && found);

  rr_pick u_pick (
    .req    (cand),
    .start  (start),
    .found  (found),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      sel_q    <= '0;
      last_q   <= 2'd3;
      hold_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q  <= GRANT;
            grant_q  <= pick_oh;
            sel_q    <= pick_idx;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (switch_lane) begin
            last_q   <= sel_q;
            hold_cnt <= '0;
            if (found) begin
              grant_q <= pick_oh;
              sel_q   <= pick_idx;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.m = '0;
    if (|grant_q)
      bus.m = bus.data[sel_q*WIDTH +: WIDTH];
  end

  assign bus.grant   = grant_q;
  assign bus.sel     = sel_q;
  assign bus.m_valid = |grant_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboarded random and directed bench for mux4_rr_arbiter, at MAX_HOLD=4 and MAX_HOLD=1.
module tb_mux4_rr_arbiter;
  localparam int W = 2;

  typedef struct {
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic [W-1:0] m;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req_s = '0;
  logic [4*W-1:0] data_s = '0;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  int own  [2];
  int age  [2];
  int last [2];
  int selm [2];
  int hlim [2] = '{4, 1};

  mux4_rr_arbiter_if #(.WIDTH(W)) bus0 ();
  mux4_rr_arbiter_if #(.WIDTH(W)) bus1 ();

  assign bus0.req  = req_s;
  assign bus0.data = data_s;
  assign bus1.req  = req_s;
  assign bus1.data = data_s;

  mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut0 (.CLOCK_50(clk), .reset(rst), .bus(bus0));
  mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut1 (.CLOCK_50(clk), .reset(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester found scanning start, start+1, ... (mod 4); -1 if none.
  function automatic int first_from(int start, logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own[d] = -1; age[d] = 0; last[d] = 3; selm[d] = 0;
    end
  endtask

  task automatic model_step(int d, logic [3:0] r);
    logic [3:0] others;
    int n;
    if (own[d] < 0) begin
      if (r != 0) begin
        own[d] = first_from(last[d] + 1, r);
        age[d] = 1; selm[d] = own[d];
      end
    end else begin
      others = r & ~(4'b0001 << own[d]);
      if (!r[own[d]] || (age[d] >= hlim[d] && others != 0)) begin
        last[d] = own[d];
        n = first_from(own[d] + 1, others);
        if (n >= 0) begin
          own[d] = n; age[d] = 1; selm[d] = n;
        end else begin
          own[d] = -1;
        end
      end else begin
        age[d]++;
      end
    end
  endtask

  function automatic exp_t model_out(int d);
    exp_t e;
    e.v     = (own[d] >= 0);
    e.grant = e.v ? (4'b0001 << own[d]) : 4'b0000;
    e.sel   = 2'(selm[d]);
    e.m     = e.v ? data_s[own[d]*W +: W] : '0;
    return e;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        model_step(0, req_s);
        model_step(1, req_s);
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
      end
    end
  end

  task automatic cmp_out(int d, exp_t e);
    logic [3:0] g;
    logic [1:0] s;
    logic [W-1:0] mm;
    logic v;
    g  = (d == 0) ? bus0.grant   : bus1.grant;
    s  = (d == 0) ? bus0.sel     : bus1.sel;
    mm = (d == 0) ? bus0.m       : bus1.m;
    v  = (d == 0) ? bus0.m_valid : bus1.m_valid;
    chk($sformatf("grant%0d", d), 32'(g), 32'(e.grant));
    chk($sformatf("sel%0d", d), 32'(s), 32'(e.sel));
    chk($sformatf("m%0d", d), 32'(mm), 32'(e.m));
    chk($sformatf("m_valid%0d", d), 32'(v), 32'(e.v));
    chk($sformatf("onehot%0d", d), 32'($onehot0(g)), 32'd1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (q0.size() == 0 || q1.size() == 0) begin
          chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd2);
        end else begin
          e = q0.pop_front(); cmp_out(0, e);
          e = q1.pop_front(); cmp_out(1, e);
        end
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_grant0"}, 32'(bus0.grant), 32'd0);
    chk({tag, "_sel0"}, 32'(bus0.sel), 32'd0);
    chk({tag, "_m0"}, 32'(bus0.m), 32'd0);
    chk({tag, "_mvalid0"}, 32'(bus0.m_valid), 32'd0);
    chk({tag, "_grant1"}, 32'(bus1.grant), 32'd0);
    chk({tag, "_mvalid1"}, 32'(bus1.m_valid), 32'd0);
  endtask

  // Reset raised between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(logic [3:0] r, logic [4*W-1:0] dv, int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      req_s  = r;
      data_s = dv;
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    drive(4'b0001, 8'b0000_0010, 3);
    drive(4'b0000, 8'b0000_0010, 2);

    async_reset();
    drive(4'b1111, 8'b1110_0100, 22);

    drive(4'b0100, 8'b1110_0100, 10);
    drive(4'b0101, 8'b1110_0100, 3);

    drive(4'b0010, 8'b1110_0100, 2);
    drive(4'b1001, 8'b1110_0100, 3);

    drive(4'b0010, 8'b1110_0100, 2);
    async_reset();
    drive(4'b1000, 8'b1110_0100, 3);

    drive(4'b0001, 8'b0110_1101, 3);
    drive(4'b0000, 8'b0110_1101, 2);
    drive(4'b0001, 8'b0110_1101, 2);

    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req_s = 4'($urandom_range(0, 15));
      data_s = 8'($urandom);
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    drive(4'b0000, 8'h00, 3);
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares the 4:1 WIDTH-bit selection mux between four requesters.
- Each requester presents a WIDTH-bit data lane and a request line.
- The block owns the 2-bit select: it grants one lane at a time, bounds each grant by a hold limit, and drives the selected lane onto the output.
- It sits between switch/peripheral sources and the LED/consumer side of the board design.

Parameters:
- WIDTH, 2, bit width of each data lane and of output m.
- MAX_HOLD, 4, minimum cycles a grant lasts before a waiting requester can preempt it. Range 1..15.

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request lines. Bit i = lane i (0=u, 1=v, 2=w, 3=x).
- data  input  4*WIDTH  packed lanes. Lane i = data[i*WIDTH +: WIDTH].
- grant  output  4  one-hot registered grant. All zero when idle.
- sel  output  2  registered index of the granted lane.
- m  output  WIDTH  selected lane. Combinational from sel_q and data. Zero when m_valid=0.
- m_valid  output  1  high while a grant is active (equals |grant).

Behaviour:
- Clocking and reset
  - One clock, CLOCK_50. Reset is asynchronous and active-high.
  - While reset=1: grant=0, sel=0, m_valid=0, m=0, hold_cnt=0, state=IDLE, last=3.
  - last=3 makes the first search after reset start at lane 0.
  - Reset asserted mid-grant clears all outputs immediately, without waiting for a clock edge.
- State machine: states IDLE and GRANT.
- IDLE
  - If req==0, stay in IDLE.
  - Otherwise, at the edge, grant the first requesting lane in the order last+1, last+2, last+3, last (mod 4).
  - Then go to GRANT with hold_cnt=0.
  - Latency: req sampled at edge k, so grant/sel/m_valid are valid after edge k.
- GRANT (current lane g)
  - m = data[g*WIDTH +: WIDTH]. Changes on data propagate combinationally.
  - hold_cnt increments each cycle and saturates at MAX_HOLD-1.
- Release (req[g]=0 at an edge)
  - Set last=g.
  - If another lane requests, grant the next one in RR order starting at g+1 at that same edge. There is no idle bubble; hold_cnt=0.
  - If no other lane requests, go to IDLE and set grant=0, m_valid=0.
- Preempt (req[g]=1, hold_cnt==MAX_HOLD-1, and any other lane requesting at the edge)
  - Set last=g and grant the next RR lane. hold_cnt=0.
- Sole requester: if req[g]=1 and no other lane requests, keep the grant indefinitely. hold_cnt stays saturated.
- Grant invariants
  - grant is always one-hot or zero.
  - A lane is never granted unless its req bit was high at the granting edge.
  - sel keeps its last value in IDLE, but m is forced to 0 there.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0… with exactly MAX_HOLD cycles each.
- MAX_HOLD=1 means a lane can be preempted after a single cycle.
- Simultaneous release and new request: a lane that raises req at the same edge the current lane drops req takes part in that edge's RR search.

Decomposition:
- Package mux_arb_pkg holds:
  - constants N_REQ=4 and SEL_W=2;
  - typedef enum logic {IDLE, GRANT} arb_state_t.
- Sub-module rr_pick: combinational. Inputs are a 4-bit request vector and a 2-bit start pointer. Outputs are found, a 2-bit index and a one-hot vector. Search order is start, start+1, start+2, start+3 (mod 4).
- The top level instantiates rr_pick once with start=cur+1 and masked requests. When the current lane is released (req[g]=0), its bit is already 0. When preempting, the current lane's bit is masked to 0.

Test Plan:
- Reset, then req=0001 with lane0=2'b10 → after 1 edge: grant=0001, sel=0, m=2'b10, m_valid=1.
- req=1111 held, MAX_HOLD=4, lanes u=0,v=1,w=2,x=3 → m sequence 0×4, 1×4, 2×4, 3×4, then 0 again (wrap); grant stays one-hot every cycle.
- Only req[2] held 10 cycles → grant=0100 for all 10 cycles with no rotation. Then raise req[0] → grant moves to 0001 on the next edge (hold already saturated).
- Grant on lane 1, drop req[1] with req=1001 → next edge grant=1000 (lane 3 precedes lane 0 in RR after 1), no m_valid gap.
- Async reset asserted mid-cycle during grant=0010 → grant=0, m=0, m_valid=0 with no clock edge. Release reset, req=1000 → grant=1000 after 1 edge.
- All req drop while granting lane 0 → next edge: IDLE, grant=0, m_valid=0, m=0. A later req=0001 grants lane 1? No: req=0001 grants lane 0, since it is the only requester.
